// File: rtl/fpdiv_normr.sv
// Post-divide normalize/round stage: left-normalizes the divider quotient, rounds to
// nearest-even and produces mantissa, biased exponent and status flags in 3 stages.
module fpdiv_normr #(
  parameter int WID = 16,
  parameter int FMW = 16,
  parameter int EW  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ce,
  input  logic              vld_i,
  input  logic [2*WID-1:0]  q_i,
  input  logic [2*WID-1:0]  r_i,
  input  logic [EW+1:0]     exp_i,
  input  logic              sgn_i,
  output logic              vld_o,
  output logic [FMW-1:0]    man_o,
  output logic [EW-1:0]     exp_o,
  output logic              sgn_o,
  output logic              inexact_o,
  output logic              ovf_o,
  output logic              unf_o,
  output logic              zero_o,
  output logic              busy_o
);

  localparam int QW = 2 * WID;
  localparam int LW = $clog2(QW) + 1;
  localparam logic signed [EW+1:0] E_MAX  = (EW+2)'((1 << EW) - 1);
  localparam logic signed [EW+1:0] E_BIAS = (EW+2)'(WID - 1);
  localparam logic signed [EW+1:0] E_ONE  = (EW+2)'(1);
  localparam logic signed [EW+1:0] E_ZERO = '0;

  // Highest set bit wins because the loop runs upward; all-zero input yields QW.
  function automatic logic [LW-1:0] lzc_f(input logic [QW-1:0] q);
    lzc_f = LW'(QW);
    for (int i = 0; i < QW; i++)
      if (q[i]) lzc_f = LW'(QW - 1 - i);
  endfunction

  // ---------------- stage 1: capture, leading-zero count, remainder reduce
  logic                  v1, rnz1, sgn1;
  logic [QW-1:0]         q1;
  logic [LW-1:0]         lzc1;
  logic signed [EW+1:0]  exp1;

  // NOTE: every clocked register uses <= so all stages sample the pre-edge values;
  // = here would let a later stage see this cycle's update and collapse the pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1   <= 1'b0;
      rnz1 <= 1'b0;
      sgn1 <= 1'b0;
      q1   <= '0;
      lzc1 <= '0;
      exp1 <= '0;
    end else if (ce) begin
      v1 <= vld_i;
      if (vld_i) begin
        q1   <= q_i;
        lzc1 <= lzc_f(q_i);
        rnz1 <= |r_i;
        exp1 <= $signed(exp_i);
        sgn1 <= sgn_i;
      end
    end
  end

  // ---------------- stage 2: normalize, extract guard/sticky, adjust exponent
  logic [QW-1:0]         qs;
  logic signed [EW+1:0]  e_n;
  logic                  v2, guard2, sticky2, sgn2, zero2, rnz2;
  logic [FMW-1:0]        mant2;
  logic signed [EW+1:0]  e2;

  assign qs  = q1 << lzc1;
  assign e_n = exp1 + E_BIAS - $signed({{(EW+2-LW){1'b0}}, lzc1});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2      <= 1'b0;
      guard2  <= 1'b0;
      sticky2 <= 1'b0;
      sgn2    <= 1'b0;
      zero2   <= 1'b0;
      rnz2    <= 1'b0;
      mant2   <= '0;
      e2      <= '0;
    end else if (ce) begin
      v2 <= v1;
      if (v1) begin
        mant2   <= qs[QW-1 -: FMW];
        guard2  <= qs[QW-1-FMW];
        sticky2 <= (|qs[QW-2-FMW:0]) | rnz1;
        e2      <= e_n;
        sgn2    <= sgn1;
        zero2   <= (q1 == '0);
        rnz2    <= rnz1;
      end
    end
  end

  // ---------------- stage 3: round-to-nearest-even and exception flags
  logic                  inc;
  logic [FMW:0]          man_sum;
  logic [FMW-1:0]        man_r, man_n;
  logic signed [EW+1:0]  e_r;
  logic [EW-1:0]         exp_n;
  logic                  inexact_n, ovf_n, unf_n, zero_n;

  // NOTE: every signal assigned below gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    inc     = guard2 & (sticky2 | mant2[0]);
    man_sum = {1'b0, mant2} + {{FMW{1'b0}}, inc};
    man_r   = man_sum[FMW-1:0];
    e_r     = e2;
    if (man_sum[FMW]) begin
      man_r = {1'b1, {(FMW-1){1'b0}}};
      e_r   = e2 + E_ONE;
    end

    man_n     = man_r;
    exp_n     = e_r[EW-1:0];
    inexact_n = guard2 | sticky2;
    ovf_n     = 1'b0;
    unf_n     = 1'b0;
    zero_n    = 1'b0;
    if (zero2) begin
      man_n     = '0;
      exp_n     = '0;
      zero_n    = 1'b1;
      inexact_n = rnz2;
    end else if (e_r >= E_MAX) begin
      man_n     = '0;
      exp_n     = '1;
      ovf_n     = 1'b1;
      inexact_n = 1'b1;
    end else if (e_r <= E_ZERO) begin
      man_n     = '0;
      exp_n     = '0;
      unf_n     = 1'b1;
      inexact_n = 1'b1;
    end
  end

  // Result fields load only with a valid result so they hold between results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_o     <= 1'b0;
      man_o     <= '0;
      exp_o     <= '0;
      sgn_o     <= 1'b0;
      inexact_o <= 1'b0;
      ovf_o     <= 1'b0;
      unf_o     <= 1'b0;
      zero_o    <= 1'b0;
    end else if (ce) begin
      vld_o <= v2;
      if (v2) begin
        man_o     <= man_n;
        exp_o     <= exp_n;
        sgn_o     <= sgn2;
        inexact_o <= inexact_n;
        ovf_o     <= ovf_n;
        unf_o     <= unf_n;
        zero_o    <= zero_n;
      end
    end
  end

  assign busy_o = v1 | v2 | vld_o;

endmodule

// File: tb/tb_fpdiv_normr.sv
// Randomized self-checking bench for fpdiv_normr against an arithmetic reference model
// followed by a ce-gated three-slot delay line.
module tb_fpdiv_normr;

  logic        clk = 1'b0;
  logic        rst_n, ce, vld_i, sgn_i;
  logic [31:0] q_i, r_i;
  logic [9:0]  exp_i;
  logic        vld_o, sgn_o, inexact_o, ovf_o, unf_o, zero_o, busy_o;
  logic [15:0] man_o;
  logic [7:0]  exp_o;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic        vld;
    logic [15:0] man;
    logic [7:0]  exp;
    logic        sgn;
    logic        inex;
    logic        ovf;
    logic        unf;
    logic        zero;
  } res_t;

  res_t pipe [3];

  fpdiv_normr #(.WID(16), .FMW(16), .EW(8)) dut (
    .clk(clk), .rst_n(rst_n), .ce(ce), .vld_i(vld_i), .q_i(q_i), .r_i(r_i),
    .exp_i(exp_i), .sgn_i(sgn_i), .vld_o(vld_o), .man_o(man_o), .exp_o(exp_o),
    .sgn_o(sgn_o), .inexact_o(inexact_o), .ovf_o(ovf_o), .unf_o(unf_o),
    .zero_o(zero_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, act, exp);
    end
  endtask

  // Value-level model: quotient q/2^16 scaled to a 16-bit mantissa by its MSB position,
  // rounded to nearest-even using the dropped bits plus the nonzero remainder.
  function automatic res_t ref_model(input logic [31:0] q, input logic [31:0] r,
                                     input int exp_v, input logic s);
    res_t o;
    int p, sh, e;
    longint unsigned qq, m, rem, half;
    logic up, rnz;
    o = '0;
    o.vld = 1'b1;
    o.sgn = s;
    rnz = (r != 0);
    if (q == 0) begin
      o.zero = 1'b1;
      o.inex = rnz;
      return o;
    end
    qq = q;
    p = 31;
    while (q[p] == 1'b0) p--;
    if (p >= 15) begin
      sh   = p - 15;
      m    = qq >> sh;
      rem  = qq & ((64'd1 << sh) - 1);
      half = (sh > 0) ? (64'd1 << (sh - 1)) : 64'd0;
    end else begin
      sh   = 0;
      m    = qq << (15 - p);
      rem  = 0;
      half = 0;
    end
    up = (sh > 0) && ((rem > half) || (rem == half && (rnz || m[0])));
    e = exp_v + p - 16;
    m = m + (up ? 64'd1 : 64'd0);
    if (m == 64'd65536) begin
      m = 64'd32768;
      e = e + 1;
    end
    if (e >= 255) begin
      o.ovf = 1'b1; o.exp = 8'hFF; o.man = '0; o.inex = 1'b1;
    end else if (e <= 0) begin
      o.unf = 1'b1; o.exp = '0; o.man = '0; o.inex = 1'b1;
    end else begin
      o.man  = m[15:0];
      o.exp  = e[7:0];
      o.inex = (rem != 0) || rnz;
    end
    return o;
  endfunction

  task automatic compare_all();
    check("vld_o",     {31'b0, vld_o},     {31'b0, pipe[2].vld});
    check("busy_o",    {31'b0, busy_o},    {31'b0, pipe[0].vld | pipe[1].vld | pipe[2].vld});
    check("man_o",     {16'b0, man_o},     {16'b0, pipe[2].man});
    check("exp_o",     {24'b0, exp_o},     {24'b0, pipe[2].exp});
    check("sgn_o",     {31'b0, sgn_o},     {31'b0, pipe[2].sgn});
    check("inexact_o", {31'b0, inexact_o}, {31'b0, pipe[2].inex});
    check("ovf_o",     {31'b0, ovf_o},     {31'b0, pipe[2].ovf});
    check("unf_o",     {31'b0, unf_o},     {31'b0, pipe[2].unf});
    check("zero_o",    {31'b0, zero_o},    {31'b0, pipe[2].zero});
  endtask

  // Drive one cycle of inputs at the falling edge, advance the model at the rising
  // edge, then compare at the next falling edge.
  task automatic tick(input logic c, input logic v, input logic [31:0] q,
                      input logic [31:0] r, input int e, input logic s);
    res_t nxt;
    ce = c; vld_i = v; q_i = q; r_i = r; exp_i = 10'(e); sgn_i = s;
    nxt = v ? ref_model(q, r, e, s) : res_t'('0);
    @(posedge clk);
    if (rst_n && c) begin
      if (pipe[1].vld) pipe[2] = pipe[1];
      else pipe[2].vld = 1'b0;
      pipe[1] = pipe[0];
      pipe[0] = nxt;
    end
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b1, 1'b0, '0, '0, 0, 1'b0);
  endtask

  task automatic clear_model();
    for (int i = 0; i < 3; i++) pipe[i] = '0;
  endtask

  logic [31:0] rq, rr;
  int          re;

  initial begin
    rst_n = 1'b0; ce = 1'b0; vld_i = 1'b0; q_i = '0; r_i = '0; exp_i = '0; sgn_i = 1'b0;
    clear_model();
    repeat (2) @(negedge clk);
    compare_all();
    rst_n = 1'b1;
    idle(2);

    // Directed vectors from the plan, each followed by enough idle cycles to drain.
    tick(1'b1, 1'b1, 32'h004B_C83C, 32'h54, 127, 1'b1);  idle(4);
    tick(1'b1, 1'b1, 32'h0001_FFFF, 32'h0,  127, 1'b0);  idle(4);
    tick(1'b1, 1'b1, 32'h0001_0000, 32'h0,  127, 1'b0);  idle(4);
    tick(1'b1, 1'b1, 32'h0000_0000, 32'h0,  127, 1'b0);  idle(4);
    tick(1'b1, 1'b1, 32'h0000_0000, 32'h7,  127, 1'b1);  idle(4);
    tick(1'b1, 1'b1, 32'h8000_0000, 32'h0,  250, 1'b0);  idle(4);
    tick(1'b1, 1'b1, 32'h0001_0000, 32'h0,  -20, 1'b1);  idle(4);
    tick(1'b1, 1'b1, 32'h0001_8000, 32'h0,  127, 1'b0);  idle(4);
    tick(1'b1, 1'b1, 32'h0001_8000, 32'h1,  127, 1'b0);  idle(4);
    tick(1'b1, 1'b1, 32'h0000_0001, 32'h0,   16, 1'b0);  idle(4);

    // Back-to-back stream with a two-cycle ce stall in the middle.
    tick(1'b1, 1'b1, 32'h0003_1234, 32'h1, 100, 1'b0);
    tick(1'b1, 1'b1, 32'h0000_ABCD, 32'h0, 110, 1'b1);
    tick(1'b0, 1'b1, 32'hDEAD_BEEF, 32'h0, 120, 1'b0);
    tick(1'b0, 1'b0, 32'h0,         32'h0,   0, 1'b0);
    tick(1'b1, 1'b1, 32'h0012_3456, 32'h3, 130, 1'b0);
    tick(1'b1, 1'b1, 32'h0000_0F0F, 32'h0, 140, 1'b1);
    idle(5);

    // Randomized traffic with random ce gaps.
    for (int i = 0; i < 500; i++) begin
      case ($urandom_range(0, 3))
        0: rq = $urandom >> $urandom_range(0, 31);
        1: rq = (($urandom_range(1, 65535) << 16) | 32'h8000) >> $urandom_range(0, 16);
        2: rq = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
        default: rq = $urandom_range(1, 255) << $urandom_range(0, 23);
      endcase
      rr = ($urandom_range(0, 1) == 0) ? 32'h0 : $urandom;
      re = $urandom_range(0, 440) - 60;
      tick($urandom_range(0, 4) != 0, $urandom_range(0, 2) != 0, rq, rr, re,
           1'($urandom_range(0, 1)));
    end
    idle(5);

    // Reset while a result is in flight: outputs clear at once and nothing emerges.
    tick(1'b1, 1'b1, 32'h004B_C83C, 32'h54, 127, 1'b1);
    tick(1'b1, 1'b0, '0, '0, 0, 1'b0);
    rst_n = 1'b0;
    #1;
    clear_model();
    compare_all();
    tick(1'b1, 1'b1, 32'h0001_0000, 32'h0, 127, 1'b0);
    rst_n = 1'b1;
    idle(6);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fpdiv_normr.md
Name: fpdiv_normr

Overview:
- Post-divide normalize/round stage; sits directly downstream of the fixed-point divider (fpdivr8).
- Consumes the raw quotient/remainder pair, left-normalizes it, applies round-to-nearest-even and produces an FP mantissa/exponent with status flags.
- 3-stage pipeline with a valid strobe, one result per cycle. Feeds the FP result packer.

Parameters:
WID, 16, divider operand width; quotient and remainder are 2*WID bits, quotient = (a<<WID)/b
FMW, 16, output mantissa width including explicit leading one
EW, 8, output exponent width

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
ce  input  1  clock enable; low freezes all pipeline registers
vld_i  input  1  input valid; one-cycle strobe when divider done
q_i  input  2*WID  divider quotient, binary point between bits WID and WID-1
r_i  input  2*WID  divider remainder
exp_i  input  EW+2  signed pre-exponent (ea-eb+bias)
sgn_i  input  1  result sign
vld_o  output  1  result valid, one cycle per accepted input
man_o  output  FMW  normalized rounded mantissa
exp_o  output  EW  biased result exponent
sgn_o  output  1  sign passthrough
inexact_o  output  1  guard|sticky nonzero before rounding
ovf_o  output  1  exponent overflow
unf_o  output  1  exponent underflow (flush to zero)
zero_o  output  1  quotient zero
busy_o  output  1  any pipeline stage holds valid data

Behaviour:
- Reset (rst_n low, async): all stage valids, all outputs = 0. Reset mid-operation discards in-flight results; no vld_o for them after release.
- ce low: all stages hold; vld_i ignored. All timing below counts ce-high cycles.
- Latency 3: input with vld_i at cycle N -> vld_o high at cycle N+3. Back-to-back inputs accepted every cycle; no backpressure.
- S1: register inputs; lzc = leading-zero count of q_i over 2*WID bits (2*WID when q_i==0); rnz = |r_i.
- S2: qs = q << lzc; mant = qs[2*WID-1 -: FMW]; guard = next bit; sticky = OR(lower bits) | rnz; e = exp + (WID-1) - lzc, signed EW+2 bits.
- S3 round-to-nearest-even: inc = guard & (sticky | mant[0]). If mant all ones and inc: man = 1 followed by zeros, e = e+1.
- S3 flags, priority zero > ovf > unf:
  - zero: q==0 -> man_o=0, exp_o=0, zero_o=1, inexact_o=rnz.
  - ovf: e >= 2^EW-1 -> exp_o all ones, man_o=0, ovf_o=1, inexact_o=1.
  - unf: e <= 0 -> man_o=0, exp_o=0, unf_o=1, inexact_o=1 (no denormals).
  - otherwise exp_o = e[EW-1:0], inexact_o = guard|sticky.
- Outputs are registered; they hold the last result while vld_o low. Flags are valid only with vld_o.
- busy_o = OR of the three stage valid bits.

Test Plan:
- Nominal (defaults): q_i=0x004BC83C (7654/101), r_i=0x54, exp_i=127, sgn_i=1, one vld_i -> 3 cycles later vld_o=1, man_o=0x9790, exp_o=133, sgn_o=1, inexact_o=1, all other flags 0.
- Round carry-out: q_i=0x0001FFFF, r_i=0, exp_i=127 -> tie with LSB 1 rounds up: man_o=0x8000, exp_o=128, inexact_o=1.
- Exact/zero: q_i=0x00010000, r_i=0, exp_i=127 -> man_o=0x8000, exp_o=127, inexact_o=0. Then q_i=0, r_i=0 -> zero_o=1, man_o=0, exp_o=0, inexact_o=0.
- Overflow/underflow: q_i=0x80000000, exp_i=250 -> ovf_o=1, exp_o=0xFF, man_o=0. q_i=0x00010000, exp_i=-20 -> unf_o=1, exp_o=0, man_o=0.
- Throughput/ce: 4 consecutive vld_i with ce held low for 2 cycles mid-stream -> 4 vld_o pulses in input order, each delayed by exactly the stalled cycles. busy_o high throughout.
- Reset mid-flight: vld_i, then rst_n low one cycle later -> outputs 0 immediately, no vld_o after release, busy_o=0.
